// File: rtl/bitty_fetch_unit.sv
// rtl/bitty_fetch_unit.sv - instruction sequencer driving the bitty core run/done handshake
// Optional watchdog: define BITTY_FETCH_TIMEOUT_EN to enable the WAIT timeout.
module bitty_fetch_unit #(
    parameter int ADDR_WIDTH     = 8,
    parameter int PROG_LEN       = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_data,
    output logic [15:0]           instruction,
    output logic                  run,
    input  logic                  done,
    output logic                  busy,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           instr_count,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_HALT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);

    // Reject configurations that cannot be sequenced at elaboration time.
    generate
        if (PROG_LEN < 1 || PROG_LEN > (2 ** ADDR_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("bitty_fetch_unit: illegal PROG_LEN or TIMEOUT_CYCLES");
        end
    endgenerate

    state_t state;
    state_t state_next;
    logic   wd_fire;

    // The ROM address is the program counter itself; no separate address register.
    assign mem_addr = pc;

`ifdef BITTY_FETCH_TIMEOUT_EN
    logic [15:0] wd_count;
    logic        timeout_q;

    // Fires on the last permitted WAIT cycle when the core still has not answered.
    assign wd_fire     = (state == S_WAIT) && !done && (wd_count == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    // Watchdog counter cleared while issuing, counting WAIT cycles; sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_count  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wd_count <= 16'd0;
            end else if (state == S_WAIT) begin
                wd_count <= wd_count + 16'd1;
            end
            if ((state == S_IDLE || state == S_HALT) && start) begin
                timeout_q <= 1'b0;
            end else if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs; done only matters in WAIT.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy       = 1'b1;
                run        = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (done) begin
                    state_next = S_ADVANCE;
                end else if (wd_fire) begin
                    state_next = S_HALT;
                end
            end
            S_ADVANCE: begin
                busy       = 1'b1;
                state_next = (pc == LAST_PC) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Program counter, instruction latch and completed-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            instruction <= 16'd0;
            instr_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        instr_count <= 16'd0;
                    end
                end
                S_LOAD: begin
                    instruction <= mem_data;
                end
                S_ADVANCE: begin
                    if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                    if (pc != LAST_PC) pc <= pc + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb/tb_bitty_fetch_unit.sv - scoreboard bench for bitty_fetch_unit with random core latency
module tb_bitty_fetch_unit;

    localparam int AW = 3;
    localparam int PL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data = 16'd0;
    logic [15:0]   instruction;
    logic          run;
    logic          done;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;
    logic [15:0]   instr_count;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_run_cycle = 0;
    int run_seen = 0;
    int unsigned dly_lo = 2;
    int unsigned dly_hi = 2;
    bit core_silent = 1'b0;
    logic spur_done = 1'b0;
    logic core_done = 1'b0;
    logic prev_run = 1'b0;
    int pend = -1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } sb_t;
    sb_t sb[$];

    logic [15:0] rom [0:(2**AW)-1];

    assign done = core_done | spur_done;

    bitty_fetch_unit #(
        .ADDR_WIDTH(AW),
        .PROG_LEN(PL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .instruction(instruction),
        .run(run),
        .done(done),
        .busy(busy),
        .halted(halted),
        .pc(pc),
        .instr_count(instr_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction ROM.
    always @(posedge clk) mem_data <= rom[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Core model: answers each run with a done strobe after a random number of cycles.
    always @(negedge clk) begin
        if (reset) begin
            pend      = -1;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (run && !core_silent) begin
                pend = int'($urandom_range(dly_hi, dly_lo));
            end else if (pend == 0) begin
                core_done     = 1'b1;
                pend          = -1;
                exp_run_cycle = cyc + 5;
            end else if (pend > 0) begin
                pend = pend - 1;
            end
        end
    end

    // Monitor: every run pulse must match the head of the scoreboard at the predicted cycle.
    always @(negedge clk) begin
        if (!reset && run) begin
            run_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: unexpected run with instruction %0h, required no run", instruction);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("instruction", 32'(instruction), 32'(e.data));
                chk("issue_pc", 32'(pc), 32'(e.addr));
            end
            chk("run_cycle", 32'(cyc + 1), 32'(exp_run_cycle));
            chk("mem_addr_eq_pc", 32'(mem_addr), 32'(pc));
            chk("run_single_cycle", 32'(prev_run), 32'd0);
        end
        prev_run = run;
    end

    // Issue a start from IDLE/HALT, optionally holding a spurious done through FETCH..ISSUE.
    task automatic do_start(input logic spur);
        start     = 1'b1;
        spur_done = spur;
        for (int i = 0; i < PL; i++) begin
            sb_t e;
            e.addr = AW'(i);
            e.data = rom[i];
            sb.push_back(e);
        end
        exp_run_cycle = cyc + 4;
        @(negedge clk);
        start = 1'b0;
        chk("start_pc_zero", 32'(pc), 32'd0);
        chk("start_count_zero", 32'(instr_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b0;
    endtask

    // Run until HALT, pulsing start at random while busy; the model expects those to be ignored.
    task automatic run_to_halt(input bit poke);
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (poke && busy && !halted && $urandom_range(0, 5) == 0) start = 1'b1;
        end
        start = 1'b0;
        chk("reached_halt", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'(PL - 1));
        chk("halt_count", 32'(instr_count), 32'(PL));
        chk("halt_instruction", 32'(instruction), 32'(rom[PL-1]));
        chk("halt_busy", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_run"}, 32'(run), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_instruction"}, 32'(instruction), 32'd0);
        chk({tag, "_count"}, 32'(instr_count), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        rom[0] = 16'h0001;
        rom[1] = 16'h0002;
        rom[2] = 16'h0003;
        rom[3] = 16'h0004;
        for (int i = PL; i < 2 ** AW; i++) rom[i] = 16'($urandom);

        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Spurious done in IDLE.
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_pc", 32'(pc), 32'd0);
        chk("idle_count", 32'(instr_count), 32'd0);

        // Directed program 1..4, fixed core latency, start sampled at edge 10.
        while (cyc < 9) @(negedge clk);
        do_start(1'b1);
        run_to_halt(1'b0);

        // Random programs restarted from HALT with random latency and ignored starts.
        dly_lo = 0;
        dly_hi = 5;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 2 ** AW; i++) rom[i] = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_start(logic'($urandom_range(0, 1)));
            run_to_halt(1'b1);
        end

        // Reset while waiting on the third instruction, then restart.
        dly_lo   = 6;
        dly_hi   = 6;
        run_seen = 0;
        do_start(1'b0);
        begin
            int n = 0;
            while (run_seen < 3 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("third_issue_seen", 32'(run_seen), 32'd3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("midreset");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dly_lo = 1;
        dly_hi = 4;
        do_start(1'b0);
        run_to_halt(1'b0);

        // Core never answers.
        core_silent = 1'b1;
        do_start(1'b0);
`ifdef BITTY_FETCH_TIMEOUT_EN
        begin
            int n = 0;
            while (!halted && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_pc", 32'(pc), 32'd0);
        chk("to_count", 32'(instr_count), 32'd0);
`else
        repeat (100) @(negedge clk);
        chk("nodone_busy", 32'(busy), 32'd1);
        chk("nodone_halted", 32'(halted), 32'd0);
        chk("nodone_err", 32'(timeout_err), 32'd0);
        chk("nodone_pc", 32'(pc), 32'd0);
        chk("nodone_count", 32'(instr_count), 32'd0);
`endif
        chk("nodone_issued_one", 32'(sb.size()), 32'(PL - 1));
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
